// File: rtl/sift_compare_pipe.sv
// sift_compare_pipe
// Two-stage compare pipeline for one heap sift step. Stage 1 registers the
// node and the best of its children. Stage 2 decides whether the parent and
// that child swap, and applies the swap. Both stages use valid/ready
// handshaking, so a full pipeline can still accept one node per cycle.
module sift_compare_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CHILDREN = 2,
    parameter int MAX_MODE     = 0,
    parameter int TAG_WIDTH    = 8,
    localparam int IDX_W       = ($clog2(NUM_CHILDREN) > 1) ? $clog2(NUM_CHILDREN) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_valid,
    output logic                               o_in_ready,
    input  logic [DATA_WIDTH-1:0]              i_parent,
    input  logic [NUM_CHILDREN*DATA_WIDTH-1:0] i_children,
    input  logic [TAG_WIDTH-1:0]               i_tag,
    output logic                               o_valid,
    input  logic                               i_out_ready,
    output logic [DATA_WIDTH-1:0]              o_parent,
    output logic [NUM_CHILDREN*DATA_WIDTH-1:0] o_children,
    output logic                               o_swap,
    output logic [IDX_W-1:0]                   o_swap_idx,
    output logic [TAG_WIDTH-1:0]               o_tag,
    output logic [31:0]                        o_swap_count
);

    logic                               s1_valid;
    logic [DATA_WIDTH-1:0]              s1_parent;
    logic [NUM_CHILDREN*DATA_WIDTH-1:0] s1_children;
    logic [TAG_WIDTH-1:0]               s1_tag;
    logic [IDX_W-1:0]                   s1_best_idx;
    logic [DATA_WIDTH-1:0]              s1_best_key;

    logic                               s2_valid;
    logic [31:0]                        swap_count;

    logic [IDX_W-1:0]                   scan_idx;
    logic [DATA_WIDTH-1:0]              scan_key;
    logic                               swap_next;
    logic [NUM_CHILDREN*DATA_WIDTH-1:0] children_next;

    logic                               accept;
    logic                               s2_load;
    logic                               drain;

    // Strict heap ordering. Equal keys are never "better", so ties keep the
    // lower child index and equal keys never swap.
    function automatic logic better(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
        if (MAX_MODE != 0) begin
            return a > b;
        end
        return a < b;
    endfunction

    // Handshake. Stage 1 can take a new node when it is empty or when it
    // hands its node to stage 2 in this same cycle. o_in_ready never looks at
    // i_valid.
    assign drain        = s2_valid && i_out_ready;
    assign s2_load      = s1_valid && (!s2_valid || i_out_ready);
    assign o_in_ready   = !s1_valid || s2_load;
    assign accept       = i_valid && o_in_ready;
    assign o_valid      = s2_valid;
    assign o_swap_count = swap_count;

    // Linear scan for the best child. Only a strictly better key replaces
    // the current pick, so ties resolve to the lowest index.
    always_comb begin
        scan_key = i_children[DATA_WIDTH-1:0];
        scan_idx = '0;
        for (int k = 1; k < NUM_CHILDREN; k++) begin
            if (better(i_children[k*DATA_WIDTH +: DATA_WIDTH], scan_key)) begin
                scan_key = i_children[k*DATA_WIDTH +: DATA_WIDTH];
                scan_idx = IDX_W'(k);
            end
        end
    end

    // Swap decision, and the child vector after the old parent is moved into
    // the slot of the selected child.
    always_comb begin
        swap_next     = better(s1_best_key, s1_parent);
        children_next = s1_children;
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            if (swap_next && (s1_best_idx == IDX_W'(k))) begin
                children_next[k*DATA_WIDTH +: DATA_WIDTH] = s1_parent;
            end
        end
    end

    // Stage 1: capture the node and its best child on accept. Stage 1 empties
    // when its node moves on and nothing new arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_parent   <= '0;
            s1_children <= '0;
            s1_tag      <= '0;
            s1_best_idx <= '0;
            s1_best_key <= '0;
        end else if (accept) begin
            s1_valid    <= 1'b1;
            s1_parent   <= i_parent;
            s1_children <= i_children;
            s1_tag      <= i_tag;
            s1_best_idx <= scan_idx;
            s1_best_key <= scan_key;
        end else if (s2_load) begin
            s1_valid    <= 1'b0;
        end
    end

    // Stage 2: register the swapped (or unchanged) node. The outputs stay
    // frozen while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            o_parent   <= '0;
            o_children <= '0;
            o_swap     <= 1'b0;
            o_swap_idx <= '0;
            o_tag      <= '0;
        end else if (s2_load) begin
            s2_valid   <= 1'b1;
            o_parent   <= swap_next ? s1_best_key : s1_parent;
            o_children <= children_next;
            o_swap     <= swap_next;
            o_swap_idx <= s1_best_idx;
            o_tag      <= s1_tag;
        end else if (drain) begin
            s2_valid   <= 1'b0;
        end
    end

    // Count delivered results that swapped. The count saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            swap_count <= '0;
        end else if (drain && o_swap && (swap_count != 32'hFFFF_FFFF)) begin
            swap_count <= swap_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_sift_compare_pipe.sv
// tb_sift_compare_pipe
// Directed bench for sift_compare_pipe. Each accepted stimulus pushes its
// hand-computed result into a queue. A monitor pops that queue and compares
// it to every result the DUT delivers. A second instance covers max mode.
module tb_sift_compare_pipe;

    localparam int DW = 32;
    localparam int NC = 4;
    localparam int TW = 8;

    typedef struct {
        logic [DW-1:0]    parent;
        logic [NC*DW-1:0] children;
        logic             swap;
        logic [1:0]       idx;
        logic [TW-1:0]    tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic             i_valid;
    logic             o_in_ready;
    logic [DW-1:0]    i_parent;
    logic [NC*DW-1:0] i_children;
    logic [TW-1:0]    i_tag;
    logic             o_valid;
    logic             i_out_ready;
    logic [DW-1:0]    o_parent;
    logic [NC*DW-1:0] o_children;
    logic             o_swap;
    logic [1:0]       o_swap_idx;
    logic [TW-1:0]    o_tag;
    logic [31:0]      o_swap_count;

    logic             mx_valid;
    logic             mx_in_ready;
    logic [DW-1:0]    mx_parent;
    logic [2*DW-1:0]  mx_children;
    logic [TW-1:0]    mx_tag;
    logic             mx_o_valid;
    logic [DW-1:0]    mx_o_parent;
    logic [2*DW-1:0]  mx_o_children;
    logic             mx_o_swap;
    logic [0:0]       mx_o_swap_idx;
    logic [TW-1:0]    mx_o_tag;
    logic [31:0]      mx_o_swap_count;

    exp_t sb[$];
    exp_t mx_sb[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    sift_compare_pipe #(
        .DATA_WIDTH(DW), .NUM_CHILDREN(NC), .MAX_MODE(0), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .o_in_ready(o_in_ready),
        .i_parent(i_parent), .i_children(i_children), .i_tag(i_tag),
        .o_valid(o_valid), .i_out_ready(i_out_ready),
        .o_parent(o_parent), .o_children(o_children),
        .o_swap(o_swap), .o_swap_idx(o_swap_idx), .o_tag(o_tag),
        .o_swap_count(o_swap_count)
    );

    sift_compare_pipe #(
        .DATA_WIDTH(DW), .NUM_CHILDREN(2), .MAX_MODE(1), .TAG_WIDTH(TW)
    ) dut_max (
        .clk(clk), .rst(rst),
        .i_valid(mx_valid), .o_in_ready(mx_in_ready),
        .i_parent(mx_parent), .i_children(mx_children), .i_tag(mx_tag),
        .o_valid(mx_o_valid), .i_out_ready(1'b1),
        .o_parent(mx_o_parent), .o_children(mx_o_children),
        .o_swap(mx_o_swap), .o_swap_idx(mx_o_swap_idx), .o_tag(mx_o_tag),
        .o_swap_count(mx_o_swap_count)
    );

    function automatic logic [NC*DW-1:0] pk(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                                            input logic [DW-1:0] c2, input logic [DW-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one node into the main DUT, hold it until it is accepted, then
    // queue its expected result.
    task automatic applyStimulus(input logic [DW-1:0] p, input logic [NC*DW-1:0] ch, input logic [TW-1:0] tag,
                                 input logic [DW-1:0] ep, input logic [NC*DW-1:0] ech,
                                 input logic es, input logic [1:0] ei);
        exp_t e;
        bit   accepted = 1'b0;
        @(negedge clk);
        i_valid    = 1'b1;
        i_parent   = p;
        i_children = ch;
        i_tag      = tag;
        for (int c = 0; c < 50 && !accepted; c++) begin
            #1;
            accepted = o_in_ready;
            @(posedge clk);
            if (!accepted) @(negedge clk);
        end
        if (accepted) begin
            e.parent = ep; e.children = ech; e.swap = es; e.idx = ei; e.tag = tag;
            sb.push_back(e);
        end else begin
            checks++;
            $display("[TB] FAIL accept_timeout: tag %0h not accepted, expected accept within 50 cycles", tag);
        end
        #1 i_valid = 1'b0;
    endtask

    // Drive one node into the max-mode instance. That instance never sees
    // backpressure.
    task automatic applyStimulusMax(input logic [DW-1:0] p, input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                                    input logic [TW-1:0] tag, input logic [DW-1:0] ep,
                                    input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                    input logic es, input logic ei);
        exp_t e;
        @(negedge clk);
        mx_valid    = 1'b1;
        mx_parent   = p;
        mx_children = {c1, c0};
        mx_tag      = tag;
        #1;
        checkOutput("max_in_ready", 256'(mx_in_ready), 256'(1'b1));
        @(posedge clk);
        e.parent = ep; e.children = pk(e0, e1, 32'd0, 32'd0); e.swap = es; e.idx = {1'b0, ei}; e.tag = tag;
        mx_sb.push_back(e);
        #1 mx_valid = 1'b0;
    endtask

    task automatic waitDrain();
        bit done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            #3;
            done = (sb.size() == 0) && !o_valid && (mx_sb.size() == 0) && !mx_o_valid;
        end
        if (!done) begin
            checks++;
            $display("[TB] FAIL drain_timeout: %0d/%0d results outstanding, expected 0", sb.size(), mx_sb.size());
        end
    endtask

    // Main-DUT monitor: every delivered result must match the head of the queue.
    initial begin : monitor_main
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && o_valid && i_out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_output: tag %0h delivered, expected no result", o_tag);
                end else begin
                    e = sb.pop_front();
                    checkOutput($sformatf("result_tag_%0h", e.tag),
                                256'({o_parent, o_children, o_swap, o_swap_idx, o_tag}),
                                256'({e.parent, e.children, e.swap, e.idx, e.tag}));
                end
            end
        end
    end

    // Max-mode monitor.
    initial begin : monitor_max
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && mx_o_valid) begin
                if (mx_sb.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_max_output: tag %0h delivered, expected no result", mx_o_tag);
                end else begin
                    e = mx_sb.pop_front();
                    checkOutput($sformatf("max_result_tag_%0h", e.tag),
                                256'({mx_o_parent, mx_o_children, mx_o_swap, mx_o_swap_idx, mx_o_tag}),
                                256'({e.parent, e.children[2*DW-1:0], e.swap, e.idx[0], e.tag}));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1; i_valid = 1'b0; i_out_ready = 1'b1;
        i_parent = '0; i_children = '0; i_tag = '0;
        mx_valid = 1'b0; mx_parent = '0; mx_children = '0; mx_tag = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_handshake", 256'({o_valid, o_in_ready}), 256'(2'b01));
        checkOutput("reset_count", 256'(o_swap_count), 256'(0));
        checkOutput("reset_regs", 256'({o_parent, o_children, o_swap, o_swap_idx, o_tag}), 256'(0));

        // Exact two-cycle latency from an idle pipeline.
        applyStimulus(32'd50, pk(30, 10, 40, 10), 8'h01, 32'd10, pk(30, 50, 40, 10), 1'b1, 2'd1);
        @(negedge clk); #1;
        checkOutput("latency_cycle1_valid", 256'(o_valid), 256'(1'b0));
        @(negedge clk); #1;
        checkOutput("latency_cycle2_valid", 256'(o_valid), 256'(1'b1));

        // Back-to-back stream: equal keys, ties, a non-better best child, wide keys.
        applyStimulus(32'd5, pk(5, 9, 5, 9), 8'h02, 32'd5, pk(5, 9, 5, 9), 1'b0, 2'd0);
        applyStimulus(32'd100, pk(200, 150, 120, 101), 8'h03, 32'd100, pk(200, 150, 120, 101), 1'b0, 2'd3);
        applyStimulus(32'd7, pk(9, 8, 7, 6), 8'h04, 32'd6, pk(9, 8, 7, 7), 1'b1, 2'd3);
        applyStimulus(32'hFFFF_FFFF, pk(0, 1, 2, 3), 8'h05, 32'd0, pk(32'hFFFF_FFFF, 1, 2, 3), 1'b1, 2'd0);
        waitDrain();
        checkOutput("count_after_stream", 256'(o_swap_count), 256'(32'd3));

        // Backpressure: two nodes fill the pipe, and the head result must hold.
        @(negedge clk);
        i_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(32'(20 + i), pk(32'(i), 100, 100, 100), 8'(8'h10 + i),
                          32'(i), pk(32'(20 + i), 100, 100, 100), 1'b1, 2'd0);
        end
        @(negedge clk); #1;
        checkOutput("stall_in_ready", 256'({o_in_ready, o_valid}), 256'(2'b01));
        checkOutput("stall_head_a", 256'({o_parent, o_tag}), 256'({32'd0, 8'h10}));
        @(negedge clk); #1;
        checkOutput("stall_head_b", 256'({o_valid, o_parent, o_tag}), 256'({1'b1, 32'd0, 8'h10}));
        i_out_ready = 1'b1;
        for (int i = 2; i < 6; i++) begin
            applyStimulus(32'(20 + i), pk(32'(i), 100, 100, 100), 8'(8'h10 + i),
                          32'(i), pk(32'(20 + i), 100, 100, 100), 1'b1, 2'd0);
        end
        waitDrain();
        checkOutput("count_after_backpressure", 256'(o_swap_count), 256'(32'd9));

        // Reset with both stages full. i_valid is held during reset and must be ignored.
        @(negedge clk);
        i_out_ready = 1'b0;
        applyStimulus(32'd50, pk(30, 10, 40, 10), 8'h20, 32'd10, pk(30, 50, 40, 10), 1'b1, 2'd1);
        applyStimulus(32'd50, pk(30, 10, 40, 10), 8'h21, 32'd10, pk(30, 50, 40, 10), 1'b1, 2'd1);
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b1; i_tag = 8'hEE;
        sb.delete();
        @(negedge clk);
        rst = 1'b0; i_valid = 1'b0;
        #1;
        checkOutput("midreset_handshake", 256'({o_valid, o_in_ready}), 256'(2'b01));
        checkOutput("midreset_count", 256'(o_swap_count), 256'(0));
        i_out_ready = 1'b1;
        repeat (6) @(negedge clk);
        applyStimulus(32'd5, pk(5, 9, 5, 9), 8'h30, 32'd5, pk(5, 9, 5, 9), 1'b0, 2'd0);
        waitDrain();
        checkOutput("count_after_noswap", 256'(o_swap_count), 256'(0));

        // Saturation: preload the counter next to its ceiling.
        @(negedge clk);
        force dut.swap_count = 32'hFFFF_FFFE;
        #1;
        release dut.swap_count;
        checkOutput("count_preload", 256'(o_swap_count), 256'(32'hFFFF_FFFE));
        applyStimulus(32'd50, pk(30, 10, 40, 10), 8'h40, 32'd10, pk(30, 50, 40, 10), 1'b1, 2'd1);
        waitDrain();
        checkOutput("count_reaches_max", 256'(o_swap_count), 256'(32'hFFFF_FFFF));
        applyStimulus(32'd50, pk(30, 10, 40, 10), 8'h41, 32'd10, pk(30, 50, 40, 10), 1'b1, 2'd1);
        applyStimulus(32'd50, pk(30, 10, 40, 10), 8'h42, 32'd10, pk(30, 50, 40, 10), 1'b1, 2'd1);
        waitDrain();
        checkOutput("count_saturated", 256'(o_swap_count), 256'(32'hFFFF_FFFF));

        // Max-heap ordering on the two-child instance.
        applyStimulusMax(32'd3, 32'd7, 32'd9, 8'h50, 32'd9, 32'd7, 32'd3, 1'b1, 1'b1);
        applyStimulusMax(32'd9, 32'd4, 32'd9, 8'h51, 32'd9, 32'd4, 32'd9, 1'b0, 1'b1);
        applyStimulusMax(32'd5, 32'd8, 32'd8, 8'h52, 32'd8, 32'd5, 32'd8, 1'b1, 1'b0);
        waitDrain();
        checkOutput("max_count", 256'(mx_o_swap_count), 256'(32'd2));
        checkOutput("queues_empty", 256'(sb.size() + mx_sb.size()), 256'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sift_compare_pipe.md
SIFT_COMPARE_PIPE -- requirements
Module: sift_compare_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning bit width of every key.
REQ-002 SHALL have parameter NUM_CHILDREN, default 2, meaning the number of child keys per node; legal range 2..16.
REQ-003 SHALL have parameter MAX_MODE, default 0, meaning 0 = min-heap ordering and 1 = max-heap ordering.
REQ-004 SHALL have parameter TAG_WIDTH, default 8, meaning the width of the opaque node tag carried alongside each transaction.
REQ-005 SHALL define IDX_W = max(1, clog2(NUM_CHILDREN)).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port i_valid, input, 1 bit: the input transaction is present.
REQ-009 SHALL have port o_in_ready, output, 1 bit: the block accepts the input transaction this cycle.
REQ-010 SHALL have port i_parent, input, DATA_WIDTH bits: the parent key.
REQ-011 SHALL have port i_children, input, NUM_CHILDREN*DATA_WIDTH bits: the child keys; child k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port i_tag, input, TAG_WIDTH bits: the tag, passed through unchanged.
REQ-013 SHALL have port o_valid, output, 1 bit: a result is present.
REQ-014 SHALL have port i_out_ready, input, 1 bit: downstream accepts the result.
REQ-015 SHALL have port o_parent, output, DATA_WIDTH bits: the resulting parent key.
REQ-016 SHALL have port o_children, output, NUM_CHILDREN*DATA_WIDTH bits: the resulting child keys, using the same packing as i_children.
REQ-017 SHALL have port o_swap, output, 1 bit: the parent was exchanged with a child.
REQ-018 SHALL have port o_swap_idx, output, IDX_W bits: the index of the selected child, valid whether or not a swap occurred.
REQ-019 SHALL have port o_tag, output, TAG_WIDTH bits: the tag of the result.
REQ-020 SHALL have port o_swap_count, output, 32 bits: the saturating count of completed results with o_swap=1.

Function
REQ-021 SHALL define "better(a,b)" as a<b (unsigned) when MAX_MODE=0 and a>b (unsigned) when MAX_MODE=1.
REQ-022 SHALL register stage 1 as follows: on input accept, capture the parent, the tag, all children, and the index and key of the best child (the child k such that no child is better than it, ties resolved to the lowest index).
REQ-023 SHALL register stage 2 as follows: on the stage 1 to stage 2 transfer, apply swap = better(best_child, parent), with strict comparison so that equal keys never swap.
REQ-024 SHALL, when swap=1, output o_parent = best child, set child[best_idx] = old parent, and leave all other children unchanged.
REQ-025 SHALL, when swap=0, output all keys equal to their inputs.
REQ-026 SHALL have a latency of exactly 2 cycles from input accept to o_valid when there is no backpressure, with a throughput of 1 transaction per cycle.
REQ-027 SHALL assert o_valid exactly when stage 2 is occupied, and hold all outputs stable while o_valid=1 and i_out_ready=0.
REQ-028 SHALL compute stage 2 advance as follows: stage 2 loads when (stage 2 empty OR i_out_ready=1) and stage 1 is occupied.
REQ-029 SHALL compute stage 1 advance as follows: o_in_ready = stage 1 empty OR stage 2 loads this cycle; o_in_ready SHALL NOT depend combinationally on i_valid.
REQ-030 SHALL accept a transaction when i_valid=1 and o_in_ready=1 in the same cycle; i_valid=1 with o_in_ready=0 has no effect.
REQ-031 SHALL treat simultaneous accept, stage transfer and output drain in one cycle as legal, losing no transaction and duplicating none.
REQ-032 SHALL increment o_swap_count when o_valid=1, i_out_ready=1 and o_swap=1, and hold it at 0xFFFFFFFF once saturated.
REQ-033 SHALL keep the tag associated with its own keys through both stages.

Reset
REQ-034 SHALL, when rst=1 at a clock edge, clear both stage-occupied flags and set o_swap_count=0; o_valid=0 and o_in_ready=1 in the next cycle.
REQ-035 SHALL set key, tag, o_swap and o_swap_idx registers to 0 on reset.
REQ-036 SHALL discard all in-flight transactions on reset asserted mid-operation, produce no output for them, and ignore i_valid during any cycle with rst=1.

Verification
REQ-037 SHALL cover min mode: NUM_CHILDREN=4, parent=50, children=(30,10,40,10), i_out_ready=1 -> after 2 cycles o_parent=10, children=(30,50,40,10), o_swap=1, o_swap_idx=1.
REQ-038 SHALL cover no swap: parent=5, children=(5,9) -> o_parent=5, children unchanged, o_swap=0, o_swap_idx=0, o_swap_count unchanged.
REQ-039 SHALL cover max mode: MAX_MODE=1, parent=3, children=(7,9) -> o_parent=9, children=(7,3), o_swap_idx=1.
REQ-040 SHALL cover backpressure: stream 6 transactions with distinct tags while holding i_out_ready=0 for 4 cycles -> o_in_ready=0 after 2 accepts, the outputs hold, then all 6 tags emerge in order without loss.
REQ-041 SHALL cover reset: assert rst while both stages are full -> next cycle o_valid=0, o_in_ready=1, o_swap_count=0, and the pending tags never appear.
REQ-042 SHALL cover saturation: preload o_swap_count to 0xFFFFFFFE via continuous swaps (or forced state) and issue 3 swaps -> o_swap_count stays at 0xFFFFFFFF.
